fft_result_unloader: RTL

- Read-side counterpart of the FFT DIT load path: once the FFT core reports done, this block reads every bin from the complex dual-port RAM and streams it out on a valid/ready interface.
- It issues RAM read addresses, absorbs the 1-cycle RAM read latency with a 2-entry skid buffer, and rescales each 32-bit component to a saturated 16-bit output.
- It sits between the FFT RAM read port and any downstream consumer (DMA, UART packer, testbench sink).

---
 rtl/fft_result_unloader.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fft_result_unloader.sv
// fft_result_unloader
//   Streams every bin of the FFT result RAM out on a valid/ready port once the
//   FFT core reports done. RAM reads have one cycle of latency. A 2-entry skid
//   FIFO absorbs that latency, and the FIFO head drives m_*. Each 32-bit
//   component is arithmetically right-shifted and saturated to OUT_WIDTH bits
//   as it is captured.
//
//   Optional build macro: FFT_UNLOAD_BITREV_EN
//     defined   : ram_rd_addr is the bit-reversal of the read counter, so a
//                 bit-reversed result buffer streams out in natural order.
//     undefined : ram_rd_addr equals the read counter.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse that begins an unload (ignored while busy)
//   shift[4:0]      right shift per component, sampled on start, clamped to 16
//   ram_rd_en/addr  RAM read strobe and address
//   ram_rd_data     {re, im}, valid the cycle after the read is issued
//   m_valid/ready   output handshake
//   m_re, m_im      scaled and saturated components
//   m_index, m_last natural bin index of the beat, and a flag for bin N-1
//   busy            high from start acceptance until the final handshake
//   unload_done     one-cycle pulse after the final handshake
module fft_result_unloader #(
  parameter int N          = 8192,
  parameter int ADDR_WIDTH = $clog2(N),
  parameter int COMP_WIDTH = 32,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4:0]              shift,
  output logic                    ram_rd_en,
  output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
  input  logic [2*COMP_WIDTH-1:0] ram_rd_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUT_WIDTH-1:0]    m_re,
  output logic [OUT_WIDTH-1:0]    m_im,
  output logic [ADDR_WIDTH-1:0]   m_index,
  output logic                    m_last,
  output logic                    busy,
  output logic                    unload_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

  // Saturation bounds, sign-extended to the component width.
  localparam logic signed [COMP_WIDTH-1:0] SAT_MAX =
    {{(COMP_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [COMP_WIDTH-1:0] SAT_MIN =
    {{(COMP_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic [OUT_WIDTH-1:0] scale_sat(
    input logic [COMP_WIDTH-1:0] c,
    input logic [4:0]            sh
  );
    logic signed [COMP_WIDTH-1:0] t;
    t = $signed(c) >>> sh;
    if (t > SAT_MAX)      scale_sat = SAT_MAX[OUT_WIDTH-1:0];
    else if (t < SAT_MIN) scale_sat = SAT_MIN[OUT_WIDTH-1:0];
    else                  scale_sat = t[OUT_WIDTH-1:0];
  endfunction

  // Control state
  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  arm_q;
  logic [4:0]            shift_q;
  logic [ADDR_WIDTH-1:0] rd_cnt_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] idx_q;

  // Skid FIFO: entry 0 is the head that drives m_*
  logic [1:0]            occ_q, occ_d;
  logic [OUT_WIDTH-1:0]  e0_re_q, e0_im_q, e1_re_q, e1_im_q;
  logic [OUT_WIDTH-1:0]  e0_re_d, e0_im_d, e1_re_d, e1_im_d;

  logic                  pop, push, issue;
  logic [1:0]            outstanding;
  logic [OUT_WIDTH-1:0]  new_re, new_im;

  assign m_valid     = (occ_q != 2'd0);
  assign pop         = m_valid && m_ready;
  assign push        = inflight_q;
  assign outstanding = occ_q + {1'b0, inflight_q};

  // Two reads may be outstanding at once, counting FIFO entries and the read
  // in flight. A pop in the same cycle frees a slot. Counting that pop is what
  // keeps the stream at one beat per clock with only two entries.
  assign issue = (state_q == RUN) && arm_q && ((outstanding < 2'd2) || pop);

  assign ram_rd_en = issue;

`ifdef FFT_UNLOAD_BITREV_EN
  always_comb begin
    ram_rd_addr = '0;
    for (int b = 0; b < ADDR_WIDTH; b++) ram_rd_addr[b] = rd_cnt_q[ADDR_WIDTH-1-b];
  end
`else
  assign ram_rd_addr = rd_cnt_q;
`endif

  assign new_re = scale_sat(ram_rd_data[2*COMP_WIDTH-1:COMP_WIDTH], shift_q);
  assign new_im = scale_sat(ram_rd_data[COMP_WIDTH-1:0], shift_q);

  assign m_re        = e0_re_q;
  assign m_im        = e0_im_q;
  assign m_index     = idx_q;
  assign m_last      = (idx_q == LAST_IDX);
  assign busy        = busy_q;
  assign unload_done = done_q;

  // FSM and read/index counters.
  // The first read waits for one RUN cycle (arm_q). This gives a fixed
  // latency of three cycles from the start-sampling edge to the first m_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      arm_q      <= 1'b0;
      shift_q    <= '0;
      rd_cnt_q   <= '0;
      inflight_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      if (pop) idx_q <= idx_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            arm_q    <= 1'b0;
            shift_q  <= (shift > 5'd16) ? 5'd16 : shift;
            rd_cnt_q <= '0;
            idx_q    <= '0;
          end
        end
        RUN: begin
          arm_q <= 1'b1;
          if (issue) begin
            // The counter parks on N-1; no wrap.
            if (rd_cnt_q == LAST_IDX) state_q  <= DRAIN;
            else                      rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            arm_q    <= 1'b0;
            rd_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Skid FIFO next state. The credit rule guarantees no push while full
  // unless a pop happens in the same cycle.
  always_comb begin
    e0_re_d = e0_re_q;
    e0_im_d = e0_im_q;
    e1_re_d = e1_re_q;
    e1_im_d = e1_im_q;
    occ_d   = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          e0_re_d = new_re;
          e0_im_d = new_im;
        end else begin
          e1_re_d = new_re;
          e1_im_d = new_im;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_re_d = e1_re_q;
        e0_im_d = e1_im_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          e0_re_d = new_re;
          e0_im_d = new_im;
        end else begin
          e0_re_d = e1_re_q;
          e0_im_d = e1_im_q;
          e1_re_d = new_re;
          e1_im_d = new_im;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= '0;
      e0_re_q <= '0;
      e0_im_q <= '0;
      e1_re_q <= '0;
      e1_im_q <= '0;
    end else begin
      occ_q   <= occ_d;
      e0_re_q <= e0_re_d;
      e0_im_q <= e0_im_d;
      e1_re_q <= e1_re_d;
      e1_im_q <= e1_im_d;
    end
  end

endmodule
